vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 83 ++++++++
 tb/tb_vga_timing_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with a clk_in-to-pixel clock divider
// Ports: clk_in/reset (async, active-high); current_row/current_line raster position;
// enable (visible area); hsync/vsync (active-low); pixel_tick (first cycle of each pixel);
// frame_start (first cycle of pixel (0,0)); frame_count (8-bit, only with
// VGA_TIMING_FRAME_COUNTER_EN defined).
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk_in,
  input  logic       reset,
  output logic [9:0] current_row,
  output logic [9:0] current_line,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       pixel_tick,
`ifdef VGA_TIMING_FRAME_COUNTER_EN
  output logic [7:0] frame_count,
`endif
  output logic       frame_start
);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_ON    = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_OFF   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON    = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_OFF   = 10'(V_VISIBLE + V_FP + V_SYNC);
  logic [3:0] div;
  logic       tick;
  logic       row_wrap;
  logic [9:0] row_nxt;
  logic [9:0] line_nxt;
  logic       frame_nxt;
  always_comb begin
    tick      = div == DIV_LAST;
    row_wrap  = current_row == H_LAST;
    row_nxt   = row_wrap ? '0 : current_row + 10'd1;
    line_nxt  = !row_wrap ? current_line : (current_line == V_LAST ? '0 : current_line + 10'd1);
    frame_nxt = tick && row_nxt == '0 && line_nxt == '0;
  end
  // Decoded outputs are only refreshed on a tick, so they keep their reset
  // values until the first pixel after reset release is presented.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div          <= '0;
      current_row  <= '0;
      current_line <= '0;
      enable       <= 1'b0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      pixel_tick   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + 4'd1;
      pixel_tick  <= tick;
      frame_start <= frame_nxt;
      if (tick) begin
        current_row  <= row_nxt;
        current_line <= line_nxt;
        enable       <= row_nxt < H_VIS && line_nxt < V_VIS;
        hsync        <= !(row_nxt >= HS_ON && row_nxt < HS_OFF);
        vsync        <= !(line_nxt >= VS_ON && line_nxt < VS_OFF);
      end
    end
  end
`ifdef VGA_TIMING_FRAME_COUNTER_EN
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) frame_count <= '0;
    else if (frame_nxt) frame_count <= frame_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen with default and reduced rasters
module tb_vga_timing_gen;
  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;
  int checks = 0;
  int errors = 0;
  logic [9:0] row, line, row2, line2;
  logic en, hs, vs, pt, fs, en2, hs2, vs2, pt2, fs2;
`ifdef VGA_TIMING_FRAME_COUNTER_EN
  logic [7:0] fc, fc2, fc3;
  logic [9:0] row3, line3;
  logic en3, hs3, vs3, pt3, fs3;
`endif
  vga_timing_gen dut (
    .clk_in(clk_in), .reset(reset), .current_row(row), .current_line(line),
    .enable(en), .hsync(hs), .vsync(vs), .pixel_tick(pt),
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    .frame_count(fc),
`endif
    .frame_start(fs)
  );
  // Small raster: 8 x 6 totals, 2 clk_in per pixel, 96 clk_in per frame.
  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) d2 (
    .clk_in(clk_in), .reset(reset), .current_row(row2), .current_line(line2),
    .enable(en2), .hsync(hs2), .vsync(vs2), .pixel_tick(pt2),
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    .frame_count(fc2),
`endif
    .frame_start(fs2)
  );
`ifdef VGA_TIMING_FRAME_COUNTER_EN
  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(2), .H_FP(1), .H_SYNC(1), .H_BP(0),
    .V_VISIBLE(1), .V_FP(0), .V_SYNC(1), .V_BP(0)
  ) d3 (
    .clk_in(clk_in), .reset(reset), .current_row(row3), .current_line(line3),
    .enable(en3), .hsync(hs3), .vsync(vs3), .pixel_tick(pt3),
    .frame_count(fc3), .frame_start(fs3)
  );
`endif
  task automatic release_and_check_first_tick(input string tag);
    @(negedge clk_in);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_in);
      checks++;
      if (row !== 10'd0 || line !== 10'd0 || en !== 1'b0 || hs !== 1'b1 || vs !== 1'b1 || pt !== 1'b0 || fs !== 1'b0) begin
        errors++;
        $display("FAIL %s_pre_tick%0d got row=%0d line=%0d en=%b hs=%b vs=%b pt=%b fs=%b want 0 0 0 1 1 0 0",
                 tag, i, row, line, en, hs, vs, pt, fs);
      end
    end
    @(negedge clk_in);
    checks++;
    if (row !== 10'd1 || line !== 10'd0 || en !== 1'b1 || hs !== 1'b1 || vs !== 1'b1 || pt !== 1'b1 || fs !== 1'b0) begin
      errors++;
      $display("FAIL %s_first_tick got row=%0d line=%0d en=%b hs=%b vs=%b pt=%b fs=%b want 1 0 1 1 1 1 0",
               tag, row, line, en, hs, vs, pt, fs);
    end
    @(negedge clk_in);
    checks++;
    if (pt !== 1'b0 || row !== 10'd1) begin
      errors++;
      $display("FAIL %s_tick_pulse got pt=%b row=%0d want pt=0 row=1", tag, pt, row);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if (row !== 10'd0 || line !== 10'd0 || en !== 1'b0 || hs !== 1'b1 || vs !== 1'b1 || pt !== 1'b0 || fs !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got row=%0d line=%0d en=%b hs=%b vs=%b pt=%b fs=%b want 0 0 0 1 1 0 0",
               row, line, en, hs, vs, pt, fs);
    end
    release_and_check_first_tick("reset");
  endtask
  task automatic test_hsync;
    int n, lo, per, p;
    n = 0;
    while (hs !== 1'b0 && n < 4000) begin @(negedge clk_in); n++; end
    checks++;
    if (hs !== 1'b0 || row !== 10'd656 || line !== 10'd0 || pt !== 1'b1) begin
      errors++;
      $display("FAIL hsync_fall got hs=%b row=%0d line=%0d pt=%b want 0 656 0 1", hs, row, line, pt);
    end
    lo = 0;
    while (hs === 1'b0 && lo < 1000) begin @(negedge clk_in); lo++; end
    checks++;
    if (lo !== 384 || row !== 10'd752) begin
      errors++;
      $display("FAIL hsync_width got %0d cycles row=%0d want 384 cycles row=752", lo, row);
    end
    per = lo;
    while (hs !== 1'b0 && per < 5000) begin @(negedge clk_in); per++; end
    checks++;
    if (per !== 3200 || row !== 10'd656 || line !== 10'd1) begin
      errors++;
      $display("FAIL line_period got %0d cycles row=%0d line=%0d want 3200 656 1", per, row, line);
    end
    n = 0;
    while (pt !== 1'b1 && n < 10) begin @(negedge clk_in); n++; end
    p = 0;
    do begin @(negedge clk_in); p++; end while (pt !== 1'b1 && p < 20);
    checks++;
    if (p !== 4) begin
      errors++;
      $display("FAIL pixel_tick_period got %0d want 4", p);
    end
  endtask
  task automatic test_reset_mid_frame;
    int n;
    n = 0;
    while (row !== 10'd300 && n < 4000) begin @(negedge clk_in); n++; end
    checks++;
    if (row !== 10'd300 || line !== 10'd2 || en !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_pre got row=%0d line=%0d en=%b want 300 2 1", row, line, en);
    end
    @(posedge clk_in);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (row !== 10'd0 || line !== 10'd0 || en !== 1'b0 || hs !== 1'b1 || vs !== 1'b1 || pt !== 1'b0 || fs !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got row=%0d line=%0d en=%b hs=%b vs=%b pt=%b fs=%b want 0 0 0 1 1 0 0",
               row, line, en, hs, vs, pt, fs);
    end
    @(negedge clk_in);
    release_and_check_first_tick("restart");
  endtask
  task automatic test_vertical;
    int n, cyc, vl, ve;
    n = 0;
    while (fs2 !== 1'b1 && n < 300) begin @(negedge clk_in); n++; end
    checks++;
    if (fs2 !== 1'b1 || row2 !== 10'd0 || line2 !== 10'd0 || en2 !== 1'b1 || vs2 !== 1'b1 || hs2 !== 1'b1 || pt2 !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_state got fs=%b row=%0d line=%0d en=%b vs=%b hs=%b pt=%b want 1 0 0 1 1 1 1",
               fs2, row2, line2, en2, vs2, hs2, pt2);
    end
    cyc = 0; vl = 0; ve = 0;
    do begin
      if (pt2 === 1'b1) begin
        if (vs2 === 1'b0) vl++;
        if (en2 === 1'b1) ve++;
      end
      @(negedge clk_in);
      cyc++;
    end while (fs2 !== 1'b1 && cyc < 300);
    checks++;
    if (cyc !== 96) begin
      errors++;
      $display("FAIL frame_period got %0d cycles want 96", cyc);
    end
    checks++;
    if (vl !== 8) begin
      errors++;
      $display("FAIL vsync_ticks got %0d want 8", vl);
    end
    checks++;
    if (ve !== 12) begin
      errors++;
      $display("FAIL enable_ticks got %0d want 12", ve);
    end
    n = 0;
    while (!(pt2 === 1'b1 && row2 === 10'd7 && line2 === 10'd5) && n < 200) begin @(negedge clk_in); n++; end
    checks++;
    if (vs2 !== 1'b1 || hs2 !== 1'b1 || en2 !== 1'b0 || row2 !== 10'd7 || line2 !== 10'd5) begin
      errors++;
      $display("FAIL last_pixel got row=%0d line=%0d vs=%b hs=%b en=%b want 7 5 1 1 0", row2, line2, vs2, hs2, en2);
    end
    repeat (2) @(negedge clk_in);
    checks++;
    if (row2 !== 10'd0 || line2 !== 10'd0 || fs2 !== 1'b1 || en2 !== 1'b1) begin
      errors++;
      $display("FAIL frame_wrap got row=%0d line=%0d fs=%b en=%b want 0 0 1 1", row2, line2, fs2, en2);
    end
  endtask
`ifdef VGA_TIMING_FRAME_COUNTER_EN
  task automatic test_frame_count;
    int n, cyc;
    bit seen;
    reset = 1'b1;
    @(negedge clk_in);
    checks++;
    if (fc3 !== 8'd0) begin
      errors++;
      $display("FAIL frame_count_reset got %0d want 0", fc3);
    end
    reset = 1'b0;
    n = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk_in);
      cyc++;
      if (fs3 === 1'b1) begin
        n++;
        if (n == 255) begin
          checks++;
          if (fc3 !== 8'd255) begin
            errors++;
            $display("FAIL frame_count_255 got %0d want 255", fc3);
          end
        end
        if (n == 256) begin
          seen = 1'b1;
          checks++;
          if (fc3 !== 8'd0) begin
            errors++;
            $display("FAIL frame_count_wrap got %0d want 0", fc3);
          end
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_count_timeout got %0d frame_starts want 256", n);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_hsync();
    test_reset_mid_frame();
    test_vertical();
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    test_frame_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
